pseudo_spi_capture: RTL

//  Read-back stage of the pseudo-SPI path: clocks serial data out of the analog device's

---
 rtl/pseudo_spi_capture.sv | 89 ++++++++
 1 files changed

// File: rtl/pseudo_spi_capture.sv
// pseudo_spi_capture: clocks a word-serial scan chain out of the analog device with SCLK1/SCLK2/LAT and writes each captured word to SRAM at descending addresses.
module pseudo_spi_capture #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RESERVED_DATA_LEN = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic [7:0]                   FREQ_DIV,
  input  logic                         SPI_SI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         LAT,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_DATA_WIDTH-1:0] PO,
  output logic                         busy,
  output logic                         spi_is_done
);
  localparam int W  = MEMORY_DATA_WIDTH;
  localparam int BW = $clog2(W + 1);
  typedef enum logic [2:0] {ST_IDLE, ST_LAT, ST_S1, ST_S2, ST_GAP, ST_WR, ST_DONE} state_t;
  state_t st, nxt, prv;
  logic [7:0] cnt, fdiv;
  logic [BW-1:0] bits;
  logic [RESERVED_DATA_LEN-1:0] words, len;
  logic [MEMORY_ADDR_WIDTH-1:0] addr;
  logic [W-1:0] shreg;
  logic last;
  assign last = cnt == fdiv;
  always_comb begin
    nxt = st;
    unique case (st)
      ST_IDLE: nxt = BGN ? (DATA_LEN == '0 ? ST_DONE : ST_LAT) : ST_IDLE;
      ST_LAT, ST_S1, ST_S2: nxt = last ? ST_GAP : st;
      ST_GAP: nxt = prv == ST_LAT ? ST_S1 : prv == ST_S1 ? ST_S2 : bits < BW'(W) ? ST_S1 : ST_WR;
      ST_WR: nxt = words == len - RESERVED_DATA_LEN'(1) ? ST_DONE : ST_S1;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      st    <= ST_IDLE;
      prv   <= ST_IDLE;
      cnt   <= '0;
      fdiv  <= '0;
      bits  <= '0;
      words <= '0;
      len   <= '0;
      addr  <= '0;
      shreg <= '0;
    end else begin
      st  <= nxt;
      cnt <= nxt == st ? cnt + 8'd1 : 8'd0;
      if (st != ST_GAP) prv <= st;
      if (st == ST_IDLE && BGN) begin
        addr  <= ADDR_BGN;
        len   <= DATA_LEN;
        fdiv  <= FREQ_DIV;
        words <= '0;
        bits  <= '0;
      end
      // SPI_SI is taken in the final high cycle of SCLK2, entering at the MSB so the first bit ends in bit 0
      if (st == ST_S2 && last) begin
        shreg <= {SPI_SI, shreg[W-1:1]};
        bits  <= bits + BW'(1);
      end
      if (st == ST_WR) begin
        addr  <= addr - MEMORY_ADDR_WIDTH'(1);
        words <= words + RESERVED_DATA_LEN'(1);
        bits  <= '0;
      end
    end
  end
  assign SCLK1       = st == ST_S1;
  assign SCLK2       = st == ST_S2;
  assign LAT         = st == ST_LAT;
  assign CEN         = st != ST_WR;
  assign WEN         = st != ST_WR;
  assign A           = st == ST_WR ? addr : '0;
  assign PO          = st == ST_WR ? shreg : '0;
  assign busy        = st != ST_IDLE;
  assign spi_is_done = st == ST_DONE;
endmodule
